// File: rtl/horner_engine.sv
// Fixed-point polynomial evaluator: Horner iteration on one shared multiplier and adder.
// Define HORNER_SAT_EN to clamp overflowing narrowings instead of wrapping them.
module horner_engine #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int ORDER = 4
) (
    input  logic             clk_n,
    input  logic             rst_n,
    input  logic             coeff_we,
    input  logic [3:0]       coeff_addr,
    input  logic [WIDTH-1:0] coeff_wdata,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int W2 = 2 * WIDTH;
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    state_t state, state_next;

    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] res_q;
    logic signed [WIDTH-1:0] coeff_k;
    logic signed [WIDTH-1:0] coeff [0:ORDER];
    logic [3:0]              k;
    logic                    ovf_q;

    logic signed [W2-1:0]    full;
    logic signed [W2-1:0]    shifted;
    logic                    mul_lost;
    logic signed [WIDTH-1:0] mul_narrow;
    logic [WIDTH:0]          sum;
    logic                    add_lost;
    logic signed [WIDTH-1:0] add_narrow;
    logic                    coeff_open;

    // Shared datapath: both the multiply and the add are narrowed here, with loss detection
    always_comb begin
        full     = W2'(acc) * W2'(x);
        shifted  = full >>> FRAC;
        mul_lost = !((&shifted[W2-1:WIDTH-1]) || !(|shifted[W2-1:WIDTH-1]));
`ifdef HORNER_SAT_EN
        mul_narrow = mul_lost ? (shifted[W2-1] ? SAT_MIN : SAT_MAX) : shifted[WIDTH-1:0];
`else
        mul_narrow = shifted[WIDTH-1:0];
`endif
        coeff_k = '0;
        for (int i = 0; i <= ORDER; i++) begin
            if (k == 4'(i)) coeff_k = coeff[i];
        end
        sum      = {prod[WIDTH-1], prod} + {coeff_k[WIDTH-1], coeff_k};
        add_lost = sum[WIDTH] ^ sum[WIDTH-1];
`ifdef HORNER_SAT_EN
        add_narrow = add_lost ? (sum[WIDTH] ? SAT_MIN : SAT_MAX) : sum[WIDTH-1:0];
`else
        add_narrow = sum[WIDTH-1:0];
`endif
        coeff_open = coeff_we && (coeff_addr <= 4'(ORDER)) &&
                     ((state == IDLE) || (state == DONE));
    end

    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MUL;
            end
            MUL:  state_next = ADD;
            ADD:  state_next = (k == 4'd0) ? DONE : MUL;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Accepting reads coeff[ORDER] before any same-edge write lands, so the old value is used
    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            acc   <= '0;
            prod  <= '0;
            res_q <= '0;
            k     <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i <= ORDER; i++) coeff[i] <= '0;
        end else begin
            for (int i = 0; i <= ORDER; i++) begin
                if (coeff_open && (coeff_addr == 4'(i))) coeff[i] <= coeff_wdata;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x     <= signal;
                        acc   <= coeff[ORDER];
                        k     <= 4'(ORDER - 1);
                        ovf_q <= 1'b0;
                    end
                end
                MUL: begin
                    prod <= mul_narrow;
                    if (mul_lost) ovf_q <= 1'b1;
                end
                ADD: begin
                    acc <= add_narrow;
                    if (add_lost) ovf_q <= 1'b1;
                    if (k == 4'd0) res_q <= add_narrow;
                    else           k     <= k - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign result = res_q;
    assign ovf    = ovf_q;

endmodule
